// File: rtl/gpio_port.sv
// Bus-mapped GPIO port: per-pin output/enable, synchronised and optionally debounced inputs,
// edge-triggered interrupt status with write-1-to-clear and a single irq output.
module gpio_port #(
    parameter int unsigned WIDTH    = 8,
    parameter logic [11:0] BASE     = 12'h000,
    parameter int unsigned DEBOUNCE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      i_io_addr,
    input  logic [15:0]      i_io_wdata,
    input  logic             i_io_wr,
    input  logic             i_io_rd,
    output logic [15:0]      o_io_rdata,
    input  logic [WIDTH-1:0] i_pin_in,
    output logic [WIDTH-1:0] o_pin_out,
    output logic [WIDTH-1:0] o_pin_oe,
    output logic             o_irq
);

    localparam logic [3:0] OffIn     = 4'd0;
    localparam logic [3:0] OffOut    = 4'd1;
    localparam logic [3:0] OffOe     = 4'd2;
    localparam logic [3:0] OffRiseEn = 4'd3;
    localparam logic [3:0] OffFallEn = 4'd4;
    localparam logic [3:0] OffStatus = 4'd5;
    localparam logic [3:0] OffOutSet = 4'd6;
    localparam logic [3:0] OffOutClr = 4'd7;

    logic             w_hit;
    logic [3:0]       w_off;
    logic             w_wr_hit;
    logic             w_rd_hit;
    logic [WIDTH-1:0] w_wdata;
    logic             w_unused_wdata;

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_filt;
    logic [WIDTH-1:0] r_filt_d;

    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_oe;
    logic [WIDTH-1:0] r_rise_en;
    logic [WIDTH-1:0] r_fall_en;
    logic [WIDTH-1:0] r_status;
    logic [15:0]      r_rdata;

    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_status_nxt;
    logic [15:0]      w_rd_val;

    assign w_hit          = (i_io_addr[15:4] == BASE);
    assign w_off          = i_io_addr[3:0];
    assign w_wr_hit       = w_hit & i_io_wr;
    assign w_rd_hit       = w_hit & i_io_rd;
    assign w_wdata        = i_io_wdata[WIDTH-1:0];
    assign w_unused_wdata = ^i_io_wdata;

    // Two-flop synchroniser on the raw pads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= i_pin_in;
            r_s2 <= r_s1;
        end
    end

    generate
        if (DEBOUNCE == 0) begin : g_nofilt
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_filt <= '0;
                end else begin
                    r_filt <= r_s2;
                end
            end
        end else begin : g_filt
            localparam int unsigned   CntW   = $clog2(DEBOUNCE + 1);
            localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE - 1);

            logic [CntW-1:0]  r_cnt     [WIDTH];
            logic [CntW-1:0]  w_cnt_nxt [WIDTH];
            logic [WIDTH-1:0] w_filt_nxt;

            // Any mismatch shorter than DEBOUNCE cycles restarts the count from zero.
            always_comb begin
                w_filt_nxt = r_filt;
                for (int i = 0; i < WIDTH; i++) begin
                    w_cnt_nxt[i] = r_cnt[i];
                    if (r_s2[i] == r_filt[i]) begin
                        w_cnt_nxt[i] = '0;
                    end else if (r_cnt[i] == CntMax) begin
                        w_filt_nxt[i] = r_s2[i];
                        w_cnt_nxt[i]  = '0;
                    end else begin
                        w_cnt_nxt[i] = r_cnt[i] + CntW'(1);
                    end
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_filt <= '0;
                    for (int i = 0; i < WIDTH; i++) begin
                        r_cnt[i] <= '0;
                    end
                end else begin
                    r_filt <= w_filt_nxt;
                    r_cnt  <= w_cnt_nxt;
                end
            end
        end
    endgenerate

    assign w_rise = r_filt & ~r_filt_d;
    assign w_fall = ~r_filt & r_filt_d;
    assign w_clr  = (w_wr_hit && (w_off == OffStatus)) ? w_wdata : '0;

    // New edges are ORed in after the clear so a same-cycle set wins.
    assign w_status_nxt = (r_status & ~w_clr) | (w_rise & r_rise_en) | (w_fall & r_fall_en);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_filt_d <= '0;
            r_status <= '0;
        end else begin
            r_filt_d <= r_filt;
            r_status <= w_status_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out     <= '0;
            r_oe      <= '0;
            r_rise_en <= '0;
            r_fall_en <= '0;
        end else if (w_wr_hit) begin
            case (w_off)
                OffOut:    r_out     <= w_wdata;
                OffOe:     r_oe      <= w_wdata;
                OffRiseEn: r_rise_en <= w_wdata;
                OffFallEn: r_fall_en <= w_wdata;
                OffOutSet: r_out     <= r_out | w_wdata;
                OffOutClr: r_out     <= r_out & ~w_wdata;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_rd_val = '0;
        case (w_off)
            OffIn:     w_rd_val[WIDTH-1:0] = r_filt;
            OffOut:    w_rd_val[WIDTH-1:0] = r_out;
            OffOe:     w_rd_val[WIDTH-1:0] = r_oe;
            OffRiseEn: w_rd_val[WIDTH-1:0] = r_rise_en;
            OffFallEn: w_rd_val[WIDTH-1:0] = r_fall_en;
            OffStatus: w_rd_val[WIDTH-1:0] = r_status;
            default:   w_rd_val = '0;
        endcase
    end

    // Idle cycles return 0 so several instances can be ORed onto one read bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= w_rd_hit ? w_rd_val : 16'h0000;
        end
    end

    assign o_io_rdata = r_rdata;
    assign o_pin_out  = r_out;
    assign o_pin_oe   = r_oe;
    assign o_irq      = |r_status;

endmodule

// File: tb/tb_gpio_port.sv
// Bench for gpio_port: four instances on a shared bus, reads checked through a scoreboard queue.
module tb_gpio_port;

    typedef struct {
        string       tag;
        logic [15:0] exp;
    } rd_exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] io_addr;
    logic [15:0] io_wdata;
    logic        io_wr;
    logic        io_rd;
    logic [15:0] rdata0, rdata_db, rdata16, rdata4, rdata_all;

    logic [7:0]  pin0, pout0, poe0;
    logic [7:0]  pin_db, pout_db, poe_db;
    logic [15:0] pin16, pout16, poe16;
    logic [3:0]  pin4, pout4, poe4;
    logic        irq0, irq_db, irq16, irq4;

    int          n_checks = 0;
    int          n_err    = 0;
    rd_exp_t     sb_q[$];
    logic        rd_seen  = 1'b0;

    always #5 clk = ~clk;

    gpio_port #(.WIDTH(8), .BASE(12'h010), .DEBOUNCE(0)) u_dut0 (
        .clk(clk), .rst(rst), .i_io_addr(io_addr), .i_io_wdata(io_wdata), .i_io_wr(io_wr),
        .i_io_rd(io_rd), .o_io_rdata(rdata0), .i_pin_in(pin0), .o_pin_out(pout0),
        .o_pin_oe(poe0), .o_irq(irq0)
    );

    gpio_port #(.WIDTH(8), .BASE(12'h020), .DEBOUNCE(4)) u_dut_db (
        .clk(clk), .rst(rst), .i_io_addr(io_addr), .i_io_wdata(io_wdata), .i_io_wr(io_wr),
        .i_io_rd(io_rd), .o_io_rdata(rdata_db), .i_pin_in(pin_db), .o_pin_out(pout_db),
        .o_pin_oe(poe_db), .o_irq(irq_db)
    );

    gpio_port #(.WIDTH(16), .BASE(12'h030), .DEBOUNCE(0)) u_dut16 (
        .clk(clk), .rst(rst), .i_io_addr(io_addr), .i_io_wdata(io_wdata), .i_io_wr(io_wr),
        .i_io_rd(io_rd), .o_io_rdata(rdata16), .i_pin_in(pin16), .o_pin_out(pout16),
        .o_pin_oe(poe16), .o_irq(irq16)
    );

    gpio_port #(.WIDTH(4), .BASE(12'h040), .DEBOUNCE(0)) u_dut4 (
        .clk(clk), .rst(rst), .i_io_addr(io_addr), .i_io_wdata(io_wdata), .i_io_wr(io_wr),
        .i_io_rd(io_rd), .o_io_rdata(rdata4), .i_pin_in(pin4), .o_pin_out(pout4),
        .o_pin_oe(poe4), .o_irq(irq4)
    );

    assign rdata_all = rdata0 | rdata_db | rdata16 | rdata4;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // All bus tasks start and end on a falling edge.
    task automatic bus_write(input logic [15:0] addr, input logic [15:0] data);
        io_addr  = addr;
        io_wdata = data;
        io_wr    = 1'b1;
        @(negedge clk);
        io_wr    = 1'b0;
    endtask

    task automatic bus_read(input string tag, input logic [15:0] addr, input logic [15:0] exp);
        rd_exp_t e;
        e.tag   = tag;
        e.exp   = exp;
        sb_q.push_back(e);
        io_addr = addr;
        io_rd   = 1'b1;
        @(negedge clk);
        io_rd   = 1'b0;
    endtask

    always @(posedge clk) rd_seen <= io_rd;

    always @(negedge clk) begin
        if (rd_seen) begin
            check("sb_depth", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
                rd_exp_t e;
                e = sb_q.pop_front();
                check(e.tag, 32'(rdata_all), 32'(e.exp));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        io_addr  = '0;
        io_wdata = '0;
        io_wr    = 1'b0;
        io_rd    = 1'b0;
        pin0     = '0;
        pin_db   = 8'h02;
        pin16    = '0;
        pin4     = 4'hF;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset in the middle of activity
        bus_write(16'h0101, 16'h0055);
        bus_write(16'h0102, 16'h000F);
        check("pre_rst_out", 32'(pout0), 32'h55);
        rst = 1'b1;
        #1;
        check("rst_out", 32'(pout0), 32'h0);
        check("rst_oe", 32'(poe0), 32'h0);
        check("rst_irq", 32'({irq0, irq_db, irq16, irq4}), 32'h0);
        check("rst_rdata", 32'(rdata_all), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Readback
        bus_write(16'h0101, 16'h00A5);
        check("out_a5", 32'(pout0), 32'hA5);
        bus_write(16'h0102, 16'h00FF);
        check("oe_ff", 32'(poe0), 32'hFF);
        bus_read("rd_out", 16'h0101, 16'h00A5);
        @(negedge clk);
        check("rd_idle", 32'(rdata_all), 32'h0);
        bus_read("rd_rsvd", 16'h0108, 16'h0000);

        // Set/clear aliases and foreign base
        bus_write(16'h0101, 16'h000F);
        bus_write(16'h0106, 16'h0030);
        check("out_set", 32'(pout0), 32'h3F);
        bus_write(16'h0107, 16'h000C);
        check("out_clr", 32'(pout0), 32'h33);
        bus_write(16'h0901, 16'h00FF);
        check("out_foreign", 32'(pout0), 32'h33);

        // Rising-edge interrupt, no debounce
        bus_write(16'h0103, 16'h0001);
        pin0[0] = 1'b1;
        repeat (3) @(negedge clk);
        check("irq_early", 32'(irq0), 32'h0);
        @(negedge clk);
        check("irq_k3", 32'(irq0), 32'h1);
        bus_read("rd_status", 16'h0105, 16'h0001);
        bus_read("rd_in", 16'h0100, 16'h0001);
        bus_write(16'h0105, 16'h0001);
        check("irq_w1c", 32'(irq0), 32'h0);
        pin0[0] = 1'b0;
        repeat (6) @(negedge clk);
        check("irq_fall_ign", 32'(irq0), 32'h0);
        bus_read("rd_status0", 16'h0105, 16'h0000);

        // Clear and rise land on the same edge: the rise wins
        pin0[0] = 1'b1;
        repeat (3) @(negedge clk);
        bus_write(16'h0105, 16'h0001);
        check("irq_setwins", 32'(irq0), 32'h1);
        bus_read("rd_setwins", 16'h0105, 16'h0001);
        bus_write(16'h0105, 16'h0001);
        check("irq_clr2", 32'(irq0), 32'h0);

        // Debounce = 4: short glitch rejected
        bus_write(16'h0204, 16'h0002);
        bus_read("db_in_hi", 16'h0200, 16'h0002);
        pin_db[1] = 1'b0;
        repeat (3) @(negedge clk);
        pin_db[1] = 1'b1;
        repeat (10) @(negedge clk);
        check("db_glitch_irq", 32'(irq_db), 32'h0);
        bus_read("db_glitch_in", 16'h0200, 16'h0002);
        bus_read("db_glitch_st", 16'h0205, 16'h0000);

        // Sustained low: filt flips at k+5, status at k+6
        pin_db[1] = 1'b0;
        repeat (5) @(negedge clk);
        bus_read("db_in_k5", 16'h0200, 16'h0002);
        check("db_irq_k5", 32'(irq_db), 32'h0);
        bus_read("db_in_k6", 16'h0200, 16'h0000);
        check("db_irq_k6", 32'(irq_db), 32'h1);
        bus_read("db_status", 16'h0205, 16'h0002);

        // Full 16-bit width, both edges
        bus_write(16'h0303, 16'hFFFF);
        bus_write(16'h0304, 16'hFFFF);
        pin16 = 16'hFFFF;
        repeat (5) @(negedge clk);
        bus_read("w16_rise", 16'h0305, 16'hFFFF);
        check("w16_irq", 32'(irq16), 32'h1);
        bus_write(16'h0305, 16'hFFFF);
        check("w16_clr", 32'(irq16), 32'h0);
        pin16 = 16'h0000;
        repeat (5) @(negedge clk);
        bus_read("w16_fall", 16'h0305, 16'hFFFF);
        bus_read("w16_in", 16'h0300, 16'h0000);

        // 4-bit width: upper bits read as zero
        bus_write(16'h0401, 16'hFFFF);
        check("w4_out", 32'(pout4), 32'hF);
        bus_read("w4_rd_out", 16'h0401, 16'h000F);
        bus_read("w4_rd_in", 16'h0400, 16'h000F);
        bus_read("w4_rd_rsvd", 16'h0409, 16'h0000);

        repeat (2) @(negedge clk);
        check("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/gpio_port.md
# gpio_port

Parametrised, bus-mapped general-purpose I/O port for the J1 I/O space, generalising the fixed 8-pin GPIO in the CSR block. It provides WIDTH pins with per-pin output enable, a two-flop input synchroniser, optional per-pin debounce filtering, and per-pin rising/falling edge interrupt capture with write-1-to-clear status and a single `irq` output. Multiple instances can share the J1 I/O bus at different `BASE` addresses.

## Interface
- `WIDTH`, 8: number of pins, 1..16.
- `BASE`, 12'h000: matches `io_addr[15:4]`, selecting this instance.
- `DEBOUNCE`, 0: stable cycles required before the filtered input changes. 0 bypasses the filter.
- `clk`  in  1  clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `io_addr`  in  16  J1 I/O address.
- `io_wdata`  in  16  J1 write data.
- `io_wr`  in  1  write strobe, one cycle.
- `io_rd`  in  1  read strobe, one cycle.
- `io_rdata`  out  16  registered read data. It is 0 when not responding, so it can be OR-combined with other instances.
- `pin_in`  in  WIDTH  raw pad inputs.
- `pin_out`  out  WIDTH  output data register.
- `pin_oe`  out  WIDTH  output enable register; the tristate is built at top level.
- `irq`  out  1  equals `|irq_status`.

## Operation
- **Hit condition:** `io_addr[15:4] == BASE`. The register offset is `io_addr[3:0]`. Bits above WIDTH read as 0, and writes to them are ignored.
- **Register map:**
  - 0: IN, read-only, the filtered input.
  - 1: OUT, read/write.
  - 2: OE, read/write.
  - 3: RISE_EN, read/write.
  - 4: FALL_EN, read/write.
  - 5: STATUS, read; writing 1 clears a bit.
  - 6: OUT_SET, write-only; write 1 to set bits.
  - 7: OUT_CLR, write-only; write 1 to clear bits.
  - Offsets 8–15 read 0, and writes to them are ignored.
- **Synchroniser:** `s1 <= pin_in; s2 <= s1`.
- **Debounce, per pin:**
  - DEBOUNCE=0: `filt <= s2`.
  - Otherwise: if `s2 == filt`, the counter is cleared. Else, if `cnt == DEBOUNCE-1`, then `filt <= s2` and `cnt <= 0`. Else `cnt++`.
  - Counter width is `$clog2(DEBOUNCE+1)`. Any glitch shorter than DEBOUNCE cycles after sync is rejected and restarts the count.
- **Edge detect:** `filt_d <= filt`.
  - A rise is `filt & ~filt_d`; a fall is `~filt & filt_d`.
  - Status next value: `(status & ~clr) | (rise & RISE_EN) | (fall & FALL_EN)`.
  - `clr` is `io_wdata` gated by a STATUS write hit.
  - If a set and a clear hit the same bit in the same cycle, the set wins.
- **Enable changes:** changing RISE_EN/FALL_EN never sets status retroactively. Clearing an enable does not clear status.
- **Reads:** on `io_rd` with a hit, `io_rdata` is loaded with the addressed register on the next edge. In all other cycles it is loaded with 0.
- **Read side effects:** reads have none. A read and write in the same cycle is illegal on the J1 bus and is not checked.
- **Reset values:** all of the following are 0 during and immediately after `rst`: `pin_out`, `pin_oe`, RISE_EN, FALL_EN, status, `s1`, `s2`, `filt`, `filt_d`, all counters, `io_rdata`, `irq`.
- **Reset mid-operation:** debounce counts in progress and pending status are discarded.

## Timing
- Writes take effect at the edge where `io_wr` is sampled high. `pin_out`/`pin_oe` change that same edge.
- Read latency is one cycle: `io_rdata` is valid in the cycle after `io_rd` and returns to 0 the cycle after that, unless `io_rd` is repeated.
- For a `pin_in` change sampled at edge k:
  - `filt` changes at edge k+1+max(DEBOUNCE,1).
  - status and `irq` assert at edge k+2+max(DEBOUNCE,1).
- `irq` is combinational from the status flops, with no extra delay. It deasserts the edge after the W1C write that clears the last set bit.
- Back-to-back edges on a pin while status is already set leave it set; there is no count or overflow.
- Pins high at reset release produce a rise in `filt` after the sync/debounce delay. Status is not set because the enables are 0.

## Test plan
- **Reset and readback:** assert `rst` mid-run → all outputs 0. Then write OUT=0x00A5 and OE=0x00FF at BASE=0x010 → `pin_out`=0xA5 and `pin_oe`=0xFF. Reading offset 1 returns 0x00A5 one cycle after `io_rd`, then 0x0000.
- **Set/clear aliases:** with OUT=0x0F, write OUT_SET=0x30 → 0x3F. Then write OUT_CLR=0x0C → 0x33. A write with a non-matching BASE leaves `pin_out` unchanged.
- **Edge interrupt:** DEBOUNCE=0, RISE_EN=0x01. Raise `pin_in[0]` before edge k → `irq`=1 at edge k+3 and STATUS reads 0x0001. Write STATUS=0x0001 → `irq`=0 on the next edge. Lowering the pin does not set status.
- **Debounce:** DEBOUNCE=4, FALL_EN=0x02.
  - A 3-cycle low glitch on `pin_in[1]` → no status, and IN is unchanged.
  - A sustained low → `filt` changes at edge k+5 and status bit 1 sets at k+6.
- **Simultaneous set/clear:** time a W1C STATUS=0x01 write to the same cycle a rise is detected on pin 0 → status bit 0 remains 1 and `irq` stays high.
- **WIDTH boundary:** with WIDTH=16, toggle all pins with both enables set → STATUS=0xFFFF. With WIDTH=4, reading IN and OUT returns 0 in bits 15:4.
